// File: rtl/debounce_pkg.sv
// Shared types and constants for the push-button debounce controller.
//   state_t        : 2-bit Moore state encoding of the debounce FSM
//   TIMER_TERMINAL : count at which the external delay timer pulses timerOF[0]
//   PRESS_CNT_W    : width of the debounced press counter
package debounce_pkg;

  typedef enum logic [1:0] {
    S_LOW     = 2'd0,
    S_WAIT_HI = 2'd1,
    S_HIGH    = 2'd2,
    S_WAIT_LO = 2'd3
  } state_t;

  localparam int unsigned TIMER_TERMINAL = 50;
  localparam int unsigned PRESS_CNT_W    = 8;

  // True in the two qualification states, where the delay timer must run.
  function automatic logic is_wait(input state_t s);
    return (s == S_WAIT_HI) || (s == S_WAIT_LO);
  endfunction

  // Debounced level: high once a press is qualified, until a release is.
  function automatic logic is_level_high(input state_t s);
    return (s == S_HIGH) || (s == S_WAIT_LO);
  endfunction

endpackage

// File: rtl/btn_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
//   SYNC_STAGES : number of flops in the chain (minimum 2)
//   i_clk       : destination clock
//   i_rst_n     : asynchronous active-low reset, clears every stage to 0
//   i_async     : asynchronous input
//   o_sync      : synchronised output (last flop of the chain)
module btn_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_async,
  output logic o_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= '0;
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], i_async};
    end
  end

  assign o_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_ctrl.sv
// Push-button debounce controller driving an external delay timer.
// The raw button is synchronised, then a 4-state Moore FSM qualifies each
// level change by waiting for the timer's terminal-count pulse while the
// synchronised input stays at the new level.
//   SYNC_STAGES : synchroniser depth on btn_raw (minimum 2)
//   clock       : system clock, rising edge
//   rst         : asynchronous active-low reset
//   btn_raw     : raw bouncing button, 1 = pressed
//   timerOF     : delay timer terminal count; only bit 0 is used
//   timerstart  : 1 = timer counts, 0 = timer held at zero
//   btn_level   : debounced level
//   btn_press   : one-cycle pulse on each debounced press
//   press_count : debounced press counter, wraps modulo 256
//   btn_release : one-cycle pulse on each debounced release
//                 (only when DEBOUNCE_RELEASE_PULSE_EN is defined)
module debounce_ctrl
  import debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clock,
  input  logic                   rst,
  input  logic                   btn_raw,
  input  logic [1:0]             timerOF,
  output logic                   timerstart,
  output logic                   btn_level,
  output logic                   btn_press,
  output logic [PRESS_CNT_W-1:0] press_count
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  ,
  output logic                   btn_release
`endif
);

  logic   w_btn_s;
  logic   w_tof;
  logic   w_unused;
  state_t r_state;
  state_t w_state_nxt;
  logic   w_press_evt;
  logic   w_timerstart_nxt;
  logic   w_level_nxt;

  logic                   r_timerstart;
  logic                   r_level;
  logic                   r_press;
  logic [PRESS_CNT_W-1:0] r_press_count;

  assign w_tof    = timerOF[0];
  assign w_unused = timerOF[1];

  btn_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (clock),
    .i_rst_n(rst),
    .i_async(btn_raw),
    .o_sync (w_btn_s)
  );

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_state <= S_LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A change of btn_s in a WAIT state takes priority over the timer pulse,
  // so a bounce coinciding with terminal count is still rejected.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_LOW: begin
        if (w_btn_s) w_state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (!w_btn_s)   w_state_nxt = S_LOW;
        else if (w_tof) w_state_nxt = S_HIGH;
      end
      S_HIGH: begin
        if (!w_btn_s) w_state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (w_btn_s)    w_state_nxt = S_HIGH;
        else if (w_tof) w_state_nxt = S_LOW;
      end
      default: w_state_nxt = S_LOW;
    endcase
    w_timerstart_nxt = is_wait(w_state_nxt);
    w_level_nxt      = is_level_high(w_state_nxt);
    w_press_evt      = (r_state == S_WAIT_HI) && (w_state_nxt == S_HIGH);
  end

  // Outputs are decoded from the next state so they align with the state
  // register; a bounce always passes through a stable state, forcing
  // timerstart low for at least one cycle and restarting the timer.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_timerstart  <= 1'b0;
      r_level       <= 1'b0;
      r_press       <= 1'b0;
      r_press_count <= '0;
    end else begin
      r_timerstart <= w_timerstart_nxt;
      r_level      <= w_level_nxt;
      r_press      <= w_press_evt;
      if (w_press_evt) begin
        r_press_count <= r_press_count + PRESS_CNT_W'(1);
      end
    end
  end

  assign timerstart  = r_timerstart;
  assign btn_level   = r_level;
  assign btn_press   = r_press;
  assign press_count = r_press_count;

`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic w_release_evt;
  logic r_release;

  assign w_release_evt = (r_state == S_WAIT_LO) && (w_state_nxt == S_LOW);

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      r_release <= 1'b0;
    end else begin
      r_release <= w_release_evt;
    end
  end

  assign btn_release = r_release;
`endif

endmodule

// File: tb/tb_debounce_ctrl.sv
module tb_debounce_ctrl;
  import debounce_pkg::*;

  localparam int unsigned SYNC     = 2;
  // A new level must be seen on 1 + TIMER_TERMINAL + 1 consecutive FSM samples.
  localparam int unsigned RUN_NEED = TIMER_TERMINAL + 2;
  localparam int unsigned LAT      = SYNC + RUN_NEED;

  logic       clock = 1'b0;
  logic       rst   = 1'b1;
  logic       btn_raw = 1'b0;
  logic [1:0] timerOF;
  logic       timerstart;
  logic       btn_level;
  logic       btn_press;
  logic [7:0] press_count;
`ifdef DEBOUNCE_RELEASE_PULSE_EN
  logic       btn_release;
`endif

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clock = ~clock;

  debounce_ctrl #(.SYNC_STAGES(SYNC)) dut (
    .clock      (clock),
    .rst        (rst),
    .btn_raw    (btn_raw),
    .timerOF    (timerOF),
    .timerstart (timerstart),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .press_count(press_count)
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    ,
    .btn_release(btn_release)
`endif
  );

  // Stand-in for the delay timer: counts while timerstart, else cleared.
  int unsigned tmr_cnt;
  logic        tof_junk = 1'b0;
  always @(posedge clock or negedge rst) begin
    if (!rst)            tmr_cnt <= 0;
    else if (timerstart) tmr_cnt <= tmr_cnt + 1;
    else                 tmr_cnt <= 0;
  end
  assign timerOF = {tof_junk, (tmr_cnt == TIMER_TERMINAL)};

  // Reference model: input delayed by SYNC samples; level flips once the
  // opposite value has been seen RUN_NEED times in a row.
  bit          m_sh [SYNC];
  bit          m_lvl;
  int unsigned m_run;
  bit          m_press;
  bit          m_rel;
  logic [7:0]  m_cnt;

  // Event trackers (edge numbers relative to the last clear)
  int unsigned edge_no, n_press, press_at, rise_at, fall_at, ts_falls, n_rel, rel_at;
  logic        prev_lvl, prev_ts;

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) m_sh[i] = 1'b0;
    m_lvl = 1'b0; m_run = 0; m_press = 1'b0; m_rel = 1'b0; m_cnt = 8'd0;
  endtask

  task automatic model_edge(input bit raw);
    bit x;
    x = m_sh[SYNC-1];
    for (int i = SYNC - 1; i > 0; i--) m_sh[i] = m_sh[i-1];
    m_sh[0] = raw;
    m_press = 1'b0;
    m_rel   = 1'b0;
    if (x != m_lvl) begin
      m_run++;
      if (m_run == RUN_NEED) begin
        m_lvl = x;
        m_run = 0;
        if (x) begin m_press = 1'b1; m_cnt = m_cnt + 8'd1; end
        else   m_rel = 1'b1;
      end
    end else begin
      m_run = 0;
    end
  endtask

  task automatic clear_trk();
    edge_no = 0; n_press = 0; press_at = 0; rise_at = 0; fall_at = 0;
    ts_falls = 0; n_rel = 0; rel_at = 0;
    prev_lvl = btn_level; prev_ts = timerstart;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit raw);
    btn_raw  = raw;
    tof_junk = 1'($urandom);
    @(posedge clock);
    if (!rst) model_reset();
    else      model_edge(raw);
    edge_no++;
    #1;
    chk("timerstart", 32'(timerstart), 32'(m_run != 0));
    chk("btn_level", 32'(btn_level), 32'(m_lvl));
    chk("btn_press", 32'(btn_press), 32'(m_press));
    chk("press_count", 32'(press_count), 32'(m_cnt));
`ifdef DEBOUNCE_RELEASE_PULSE_EN
    chk("btn_release", 32'(btn_release), 32'(m_rel));
    if (btn_release === 1'b1) begin n_rel++; rel_at = edge_no; end
`endif
    if (btn_press === 1'b1) begin n_press++; press_at = edge_no; end
    if (btn_level === 1'b1 && prev_lvl === 1'b0) rise_at = edge_no;
    if (btn_level === 1'b0 && prev_lvl === 1'b1) fall_at = edge_no;
    if (timerstart === 1'b0 && prev_ts === 1'b1) ts_falls++;
    prev_lvl = btn_level;
    prev_ts  = timerstart;
  endtask

  task automatic do_reset();
    @(negedge clock);
    rst = 1'b0;
    model_reset();
    repeat (2) step(1'b0);
    @(negedge clock);
    rst = 1'b1;
    clear_trk();
  endtask

  initial begin
    // Reset held with the button pressed: everything stays at zero.
    btn_raw = 1'b1;
    #1 rst = 1'b0;
    model_reset();
    repeat (5) step(1'b1);
    chk("rst_state", 32'(dut.r_state), 32'(S_LOW));
    @(negedge clock);
    rst = 1'b1;
    clear_trk();
    repeat (60) step(1'b1);
    chk("first_press_edge", press_at, LAT);
    chk("first_press_n", n_press, 1);
    chk("first_press_count", 32'(press_count), 32'd1);

    // Clean 200-cycle press then release.
    do_reset();
    repeat (200) step(1'b1);
    repeat (80)  step(1'b0);
    chk("clean_rise_edge", rise_at, LAT);
    chk("clean_fall_edge", fall_at, 200 + LAT);
    chk("clean_press_n", n_press, 1);
    chk("clean_count", 32'(press_count), 32'd1);

    // Bounce every 10 cycles, then settle high.
    do_reset();
    for (int k = 0; k < 10; k++) repeat (10) step(k % 2 == 0);
    repeat (80) step(1'b1);
    chk("bounce_press_n", n_press, 1);
    chk("bounce_press_edge", press_at, 100 + LAT);
    chk("bounce_ts_drops", ts_falls, 6);

    // 256 clean presses wrap the counter.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      repeat (56) step(1'b1);
      repeat (56) step(1'b0);
    end
    chk("wrap_press_n", n_press, 256);
    chk("wrap_count", 32'(press_count), 32'd0);

    // Reset in the middle of qualification.
    do_reset();
    repeat (10) step(1'b1);
    chk("mid_ts_before", 32'(timerstart), 32'd1);
    #2 rst = 1'b0;
    model_reset();
    #1;
    chk("mid_ts_async", 32'(timerstart), 32'd0);
    chk("mid_press", 32'(btn_press), 32'd0);
    chk("mid_level", 32'(btn_level), 32'd0);
    chk("mid_state", 32'(dut.r_state), 32'(S_LOW));
    repeat (2) step(1'b0);
    @(negedge clock);
    rst = 1'b1;
    clear_trk();
    repeat (60) step(1'b0);
    chk("mid_press_n", n_press, 0);

`ifdef DEBOUNCE_RELEASE_PULSE_EN
    // Release held 60 cycles gives a single release pulse.
    do_reset();
    repeat (60) step(1'b1);
    clear_trk();
    repeat (60) step(1'b0);
    chk("release_n", n_rel, 1);
    chk("release_edge", rel_at, LAT);
`endif

    // Randomised segments against the model.
    do_reset();
    for (int s = 0; s < 80; s++) begin
      int unsigned len;
      bit          v;
      len = $urandom_range(70, 1);
      v   = 1'($urandom_range(1, 0));
      repeat (len) step(v);
    end
    repeat (60) step(1'b0);
    chk("random_final_level", 32'(btn_level), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/debounce_ctrl.md
# debounce_ctrl

Push-button debounce controller sitting directly upstream of the `delay` timer: it synchronises a raw button input, drives the timer's `timerstart`, and consumes its `timerOF` terminal-count pulse to qualify a level change as stable. It produces a clean debounced level, a one-cycle press pulse and an 8-bit press counter for the downstream control logic.

## Interface
- `SYNC_STAGES`, default 2: number of synchroniser flops on `btn_raw`; minimum 2.
- `clock` input 1: single system clock; all logic on the rising edge.
- `rst` input 1: asynchronous, active-low reset; 0 resets, 1 runs.
- `btn_raw` input 1: raw, asynchronous, bouncing button; 1 means pressed.
- `timerOF` input 2: terminal-count output of the `delay` timer; only bit 0 is used, bit 1 is ignored.
- `timerstart` output 1: run/clear control to the `delay` timer; 1 means count, 0 means hold the timer at zero.
- `btn_level` output 1: debounced button level.
- `btn_press` output 1: one-cycle pulse on each debounced 0→1 transition.
- `press_count` output 8: number of debounced presses; wraps from 255 to 0.
- `btn_release` output 1: present only with `DEBOUNCE_RELEASE_PULSE_EN`; one-cycle pulse on each debounced 1→0 transition.

## Operation
- `btn_raw` passes through a `SYNC_STAGES` flop chain; the last flop is `btn_s`. Only `btn_s` feeds the FSM.
- The Moore FSM has four states: `S_LOW`, `S_WAIT_HI`, `S_HIGH`, `S_WAIT_LO`.
- `S_LOW`: when `btn_s`=1, go to `S_WAIT_HI`.
- `S_WAIT_HI`:
  - `btn_s`=0: return to `S_LOW` (bounce rejected).
  - `btn_s`=1 and `timerOF[0]`=1: go to `S_HIGH`.
- `S_HIGH`: when `btn_s`=0, go to `S_WAIT_LO`.
- `S_WAIT_LO`:
  - `btn_s`=1: return to `S_HIGH`.
  - `btn_s`=0 and `timerOF[0]`=1: go to `S_LOW`.
- `timerstart` is a registered decode: 1 exactly while the state is `S_WAIT_HI` or `S_WAIT_LO`.
  - Any bounce passes through a stable state, so `timerstart` drops for at least one cycle and the timer restarts from zero.
  - No transition goes directly from one WAIT state to the other.
- `btn_level` is registered: 1 in `S_HIGH` and `S_WAIT_LO`, 0 otherwise.
- On the edge that enters `S_HIGH` from `S_WAIT_HI`:
  - `btn_press` is 1 for one cycle.
  - `press_count` increments, modulo 256.
- Re-entering `S_HIGH` from `S_WAIT_LO` produces no pulse and no increment.
- `timerOF[0]` is ignored in `S_LOW` and `S_HIGH`.
- When `btn_s` changes and `timerOF[0]` is 1 in the same WAIT cycle, the `btn_s` rule wins: the FSM returns to the stable state.

## Timing
- Reset values: all sync flops 0, state `S_LOW`, `timerstart`=0, `btn_level`=0, `btn_press`=0, `press_count`=0, `btn_release`=0.
- Reset asserted mid-debounce drops `timerstart` immediately. No pulse is emitted.
- The timer pulses `timerOF[0]` when its count reaches 50, i.e. 50 edges after `timerstart` rises.
- Press latency: take edge 1 as the first edge sampling `btn_raw`=1, with a clean input.
  - Edge `SYNC_STAGES`+1: FSM enters `S_WAIT_HI`.
  - Edge `SYNC_STAGES`+52: FSM enters `S_HIGH`, `btn_level`=1, `btn_press`=1.
  - With the default of 2 this is edge 54.
- Release latency is symmetric: also `SYNC_STAGES`+52 edges.
- `btn_press` and `btn_release` are never high for two consecutive cycles.

## Configuration
- `DEBOUNCE_RELEASE_PULSE_EN` defined:
  - The `btn_release` port exists.
  - It pulses for one cycle on the edge entering `S_LOW` from `S_WAIT_LO`.
- Undefined: the port and its logic are absent. All other behaviour is identical.

## Structure
- Package `debounce_pkg`:
  - 2-bit state type and encodings: `S_LOW`=0, `S_WAIT_HI`=1, `S_HIGH`=2, `S_WAIT_LO`=3.
  - `TIMER_TERMINAL`=50 for benches.
  - `PRESS_CNT_W`=8.
- Sub-module `btn_sync`: parameterised `SYNC_STAGES` flop chain with the same asynchronous active-low reset.

## Test plan
- Reset held low, `btn_raw`=1 → all outputs 0. Release reset → `btn_press` at edge 54; `press_count`=1.
- Clean press of 200 cycles, then release → `btn_level` high from edge 54 to the release edge plus 54; exactly one `btn_press`; `press_count`=1.
- `btn_raw` toggles every 10 cycles for 100 cycles, then settles high → `timerstart` drops after each bounce; one `btn_press` 54 edges after the final rising edge.
- 256 clean presses → `press_count` wraps to 0; 256 `btn_press` pulses.
- `rst` pulsed low while `timerstart`=1 → `timerstart`=0 asynchronously; no `btn_press`; state `S_LOW`.
- With `DEBOUNCE_RELEASE_PULSE_EN`: a release held for 60 cycles → one `btn_release` pulse at edge 54 after the falling edge.
